// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one byte-addressed RAM port (via the RAM address manager) between
//   requester 0 (instruction fetch) and requester 1 (data load/store).
//   Round-robin grant with a req/ack handshake and an RD_LATENCY-cycle read
//   wait. A word access at an odd address is split into two byte accesses
//   (low byte at addr, high byte at addr+1), so requesters see no alignment
//   restrictions.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN/weN/byteN/sextN     request and access type (held until ackN)
//   addrN[17:0], wdataN[15:0] byte address, write data (byte writes use [7:0])
//   ackN                     one-cycle completion pulse
//   rdataN[15:0]             read data, valid with ackN, held until next ackN
//   busy                     high whenever the FSM is not IDLE
//   mem_addr/mem_byte/mem_sext/mem_we/mem_wdata   to the address manager
//   mem_rdata                read data from the address manager
module ram_arbiter #(
  parameter int RD_LATENCY = 1   // 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic        byte0,
  input  logic        sext0,
  input  logic [17:0] addr0,
  input  logic [15:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic        byte1,
  input  logic        sext1,
  input  logic [17:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic [15:0] rdata0,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic [17:0] mem_addr,
  output logic        mem_byte,
  output logic        mem_sext,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        gnt;
  logic        phase;
  logic        l_we;
  logic        l_byte;
  logic [17:0] l_addr;
  logic [7:0]  l_whi;     // high write byte, needed only for split phase 1
  logic [7:0]  lo;        // low byte captured in split-read phase 0
  logic [1:0]  cnt;

  // Grant selection: on a tie the requester that was not served last wins.
  logic        pick;
  logic        sel_we, sel_byte, sel_sext, sel_split;
  logic [17:0] sel_addr;
  logic [15:0] sel_wdata;

  assign pick      = req1 & (~req0 | ~last_grant);
  assign sel_we    = pick ? we1    : we0;
  assign sel_byte  = pick ? byte1  : byte0;
  assign sel_sext  = pick ? sext1  : sext0;
  assign sel_addr  = pick ? addr1  : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign sel_split = ~sel_byte & sel_addr[0];

  logic        split;
  logic [17:0] p1_addr;
  logic        wait_last;

  assign split     = ~l_byte & l_addr[0];
  assign p1_addr   = l_addr + 18'd1;   // 18-bit wrap: 0x3FFFF -> 0x00000
  assign wait_last = (cnt == 2'(RD_LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      phase      <= 1'b0;
      l_we       <= 1'b0;
      l_byte     <= 1'b0;
      l_addr     <= '0;
      l_whi      <= '0;
      lo         <= '0;
      cnt        <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_byte   <= 1'b0;
      mem_sext   <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt        <= pick;
            last_grant <= pick;
            l_we       <= sel_we;
            l_byte     <= sel_byte;
            l_addr     <= sel_addr;
            l_whi      <= sel_wdata[15:8];
            phase      <= 1'b0;
            cnt        <= '0;
            // Phase-0 issue values go out directly so ISSUE sees them registered.
            mem_addr   <= sel_addr;
            mem_byte   <= sel_byte | sel_split;
            mem_sext   <= sel_sext & ~sel_split;
            mem_wdata  <= sel_split ? {8'h00, sel_wdata[7:0]} : sel_wdata;
            mem_we     <= sel_we;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (l_we && split && !phase) begin
            // Second byte strobe of a split write; mem_we stays high.
            phase     <= 1'b1;
            mem_addr  <= p1_addr;
            mem_wdata <= {8'h00, l_whi};
            state     <= ISSUE;
          end else if (l_we) begin
            mem_we <= 1'b0;
            if (gnt) ack1 <= 1'b1;
            else     ack0 <= 1'b1;
            state  <= DONE;
          end else begin
            mem_we <= 1'b0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (!wait_last) begin
            cnt <= cnt + 2'd1;
          end else if (split && !phase) begin
            lo        <= mem_rdata[7:0];
            phase     <= 1'b1;
            mem_addr  <= p1_addr;
            mem_wdata <= {8'h00, l_whi};
            mem_we    <= 1'b0;
            state     <= ISSUE;
          end else begin
            // Split result is assembled as {hi, lo} with no sign extension.
            if (gnt) begin
              ack1   <= 1'b1;
              rdata1 <= split ? {mem_rdata[7:0], lo} : mem_rdata;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= split ? {mem_rdata[7:0], lo} : mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed bench for ram_arbiter with a behavioural byte RAM / address
//   manager model (RD_LATENCY-stage read pipeline, byte/word/sext support).
module tb_ram_arbiter;
  localparam int LAT = 1;

  logic        clk, rst;
  logic        req0, we0, byte0, sext0, req1, we1, byte1, sext1;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy, mem_byte, mem_sext, mem_we;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [17:0] mem_addr;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  ram_arbiter #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .byte0(byte0), .sext0(sext0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .byte1(byte1), .sext1(sext1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1), .busy(busy),
    .mem_addr(mem_addr), .mem_byte(mem_byte), .mem_sext(mem_sext), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address manager + RAM model: little-endian word = {ram[a+1], ram[a]}.
  logic [7:0]  ram [0:262143];
  logic [15:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    logic [17:0] a1;
    logic [7:0]  b;
    logic [15:0] rv;
    a1 = mem_addr + 18'd1;
    b  = ram[mem_addr];
    if (mem_byte) rv = mem_sext ? {{8{b[7]}}, b} : {8'h00, b};
    else          rv = {ram[a1], b};
    rd_pipe[0] <= rv;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_we) begin
      wr_count = wr_count + 1;
      ram[mem_addr] = mem_wdata[7:0];
      if (!mem_byte) ram[a1] = mem_wdata[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on a port; returns cycles from req (cycle 0) to ack, or -1.
  task automatic do_acc(input int port, input logic w, input logic bt, input logic sx,
                        input logic [17:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd);
    lat = -1;
    rd  = '0;
    if (port == 0) begin
      we0 = w; byte0 = bt; sext0 = sx; addr0 = a; wdata0 = wd; req0 = 1'b1;
    end else begin
      we1 = w; byte1 = bt; sext1 = sx; addr1 = a; wdata1 = wd; req1 = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        lat = c;
        rd  = (port == 0) ? rdata0 : rdata1;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, n, first, w0;
    logic [15:0] rd;
    int order [4];

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    rst = 1'b1;
    req0 = 0; we0 = 0; byte0 = 0; sext0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; byte1 = 0; sext1 = 0; addr1 = '0; wdata1 = '0;
    ram[18'h00010] = 8'hEF; ram[18'h00011] = 8'hBE;
    ram[18'h00020] = 8'h77; ram[18'h00023] = 8'h99;
    ram[18'h3FFFF] = 8'hAA; ram[18'h00000] = 8'h55;
    ram[18'h00003] = 8'h80; ram[18'h00044] = 8'h66;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ack",   32'({ack0, ack1}), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Contention: both writes from the same cycle, held through 4 acks
    we0 = 1; byte0 = 0; addr0 = 18'h00100; wdata0 = 16'h1111;
    we1 = 1; byte1 = 0; addr1 = 18'h00200; wdata1 = 16'h2222;
    req0 = 1; req1 = 1;
    w0 = wr_count; n = 0; first = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        chk("contend_one_ack", 32'(ack0 & ack1), 32'd0);
        if (first < 0) first = c;
        order[n] = ack1 ? 1 : 0;
        n++;
        if (n == 4) begin req0 = 0; req1 = 0; break; end
      end
    end
    @(posedge clk); #1;
    chk("contend_nacks", 32'(n), 32'd4);
    chk("contend_first_cycle", 32'(first), 32'd2);
    chk("contend_g0", 32'(order[0]), 32'd0);
    chk("contend_g1", 32'(order[1]), 32'd1);
    chk("contend_g2", 32'(order[2]), 32'd0);
    chk("contend_g3", 32'(order[3]), 32'd1);
    chk("contend_strobes", 32'(wr_count - w0), 32'd4);
    chk("contend_ram0", 32'({ram[18'h101], ram[18'h100]}), 32'h1111);
    chk("contend_ram1", 32'({ram[18'h201], ram[18'h200]}), 32'h2222);

    // Aligned word read
    do_acc(0, 0, 0, 0, 18'h00010, 16'h0, lat, rd);
    chk("rd_word_lat", 32'(lat), 32'd3);
    chk("rd_word_data", 32'(rd), 32'hBEEF);
    chk("rd_word_other", 32'(rdata1), 32'd0);

    // Aligned word write and odd-address byte write (not split)
    do_acc(0, 1, 0, 0, 18'h00040, 16'hCAFE, lat, rd);
    chk("wr_word_lat", 32'(lat), 32'd2);
    chk("wr_word_ram", 32'({ram[18'h41], ram[18'h40]}), 32'hCAFE);
    w0 = wr_count;
    do_acc(1, 1, 1, 0, 18'h00043, 16'h55AB, lat, rd);
    chk("wr_byte_lat", 32'(lat), 32'd2);
    chk("wr_byte_ram", 32'({ram[18'h44], ram[18'h43]}), 32'h66AB);
    chk("wr_byte_strobes", 32'(wr_count - w0), 32'd1);

    // Split word write at odd address
    w0 = wr_count;
    do_acc(1, 1, 0, 0, 18'h00021, 16'h1234, lat, rd);
    chk("split_wr_lat", 32'(lat), 32'd3);
    chk("split_wr_strobes", 32'(wr_count - w0), 32'd2);
    chk("split_wr_ram", 32'({ram[18'h22], ram[18'h21], ram[18'h20]}), 32'h123477);

    // Split word read wrapping 0x3FFFF -> 0x00000
    do_acc(1, 0, 0, 0, 18'h3FFFF, 16'h0, lat, rd);
    chk("split_rd_lat", 32'(lat), 32'd5);
    chk("split_rd_data", 32'(rd), 32'h55AA);

    // Byte reads with and without sign extension
    do_acc(0, 0, 1, 1, 18'h00003, 16'h0, lat, rd);
    chk("byte_sext_lat", 32'(lat), 32'd3);
    chk("byte_sext_data", 32'(rd), 32'hFF80);
    do_acc(0, 0, 1, 0, 18'h00003, 16'h0, lat, rd);
    chk("byte_zext_data", 32'(rd), 32'h0080);
    chk("rdata1_held", 32'(rdata1), 32'h55AA);

    // Reset during WAIT of a read
    we0 = 0; byte0 = 0; sext0 = 0; addr0 = 18'h00010; req0 = 1;
    repeat (3) @(negedge clk);
    chk("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; req0 = 0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_we", 32'(mem_we), 32'd0);
    n = 0;
    repeat (3) begin @(negedge clk); n += int'(ack0 | ack1); end
    chk("rstw_no_ack", 32'(n), 32'd0);
    chk("rstw_rdata", 32'(rdata0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during ISSUE of a split write: strobe drops immediately
    we0 = 1; byte0 = 0; addr0 = 18'h00031; wdata0 = 16'hA5A5; req0 = 1;
    repeat (2) @(negedge clk);
    chk("rsti_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1; req0 = 0;
    #1;
    chk("rsti_we", 32'(mem_we), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Normal service after reset
    do_acc(1, 0, 0, 0, 18'h00010, 16'h0, lat, rd);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", 32'(rd), 32'hBEEF);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
